line_follow_sequencer: RTL and testbench
========================================

Name: line_follow_sequencer

Overview:
- Upstream of the motor-driver stage. Turns the three thresholded line-sensor bits plus one queued node command into the 3-bit direction code the motor driver consumes.
- Follows the line, detects nodes, and then runs the commanded action at each node: straight, left pivot, right pivot, or halt.
- Reports completion and faults to the path planner.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive identical registered sensor samples needed before a pattern is accepted.
- CROSS_CYCLES, 31250: cycles driven forward past a node before a turn or completion (10 ms at 3.125 MHz).
- TURN_MIN_CYCLES, 156250: cycles of pivot during which the centre sensor is ignored (50 ms).
- TIMEOUT_CYCLES, 3125000: maximum cycles for line-lost or for a turn search before fault (1 s).

Ports:
- clk, input, 1: 3.125 MHz system clock.
- rst_n, input, 1: synchronous, active-low reset.
- line, input, 3: {L,C,R}; 1 = sensor over the black line.
- cmd_valid, input, 1: node command offered.
- cmd, input, 2: 0 STRAIGHT, 1 LEFT, 2 RIGHT, 3 HALT.
- cmd_ready, output, 1: high only in IDLE (decoded from the state register).
- direction, output, 3: motor code. 0 stop, 1 fwd, 2 right, 3 left, 4 reverse, 5 pivot right, 6 pivot left.
- done, output, 1: one-cycle pulse when a command completes.
- fault, output, 1: sticky until reset.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE, direction=0, done=0, fault=0, all counters 0, debounced pattern=010, last correction=1.
  - cmd_ready=1 from the first edge after release.
- Sampling: line is registered every cycle. The debounced pattern updates once DEBOUNCE_CYCLES equal consecutive registered samples have been seen. direction is registered from the debounced pattern.
- Latency: raw line change to direction change = DEBOUNCE_CYCLES+2 edges (5 at default).
- Handshake:
  - A command is accepted on an edge where cmd_valid & cmd_ready. cmd is latched at that edge.
  - cmd_valid outside IDLE is ignored and not queued.
- IDLE: direction=0. On accept, go to FOLLOW. If the latched command is HALT and the debounced pattern is already 111, go to DONE instead.
- FOLLOW, by debounced pattern:
  - 010: direction=1.
  - 110 or 100: direction=3.
  - 011 or 001: direction=2.
  - 101: direction=1.
  - 000 (line lost): hold the last correction (2, 3 or 1) and count. If the count reaches TIMEOUT_CYCLES, go to FAULT. Any non-000 pattern clears the count.
  - 111 (node): if cmd=HALT, go to DONE. Otherwise go to CROSS with direction=1.
- CROSS: direction=1 for exactly CROSS_CYCLES cycles, ignoring sensors. Then:
  - STRAIGHT: go to DONE.
  - LEFT: go to TURN, direction=6.
  - RIGHT: go to TURN, direction=5.
- TURN:
  - Pivot is held. Count cycles.
  - After TURN_MIN_CYCLES, the first debounced pattern with C=1 and not 111 goes to DONE.
  - If the count reaches TIMEOUT_CYCLES, go to FAULT. The timeout takes priority when both occur on the same edge.
- DONE: one cycle. direction=0, done=1, then IDLE.
- FAULT: direction=0, fault=1, cmd_ready=0. Held until rst_n=0.
- Counters: sized $clog2(TIMEOUT_CYCLES+1). Saturating, never wrap. Cleared on every state entry.
- Reset mid-operation: the reset values above apply on that edge. The in-flight command is discarded.
- Illegal state encodings recover to IDLE with direction=0.

Decomposition:
- Shared package sm1118_pkg holds:
  - Direction code constants DIR_STOP..DIR_PIVOT_LEFT, with the same numbering the motor driver decodes.
  - Command codes CMD_STRAIGHT..CMD_HALT.
  - State encoding.
- One sub-module, line_debounce, parameterised by width (3) and DEBOUNCE_CYCLES. Ports: clk, rst_n, raw, stable, changed pulse.

Test Plan:
- Reset then release with line=010 → direction=0, cmd_ready=1, fault=0. Accept cmd=STRAIGHT → direction=1 within 5 edges.
- FOLLOW, line 010→100 held → direction=3 exactly 5 edges after the change. A 2-cycle 100 glitch → direction stays 1.
- cmd=LEFT, present 111 → direction=1 for 31250 cycles, then 6. Line 010 at cycle 100000 of the turn is ignored. Line 010 after 156250 → done pulse once, direction=0, cmd_ready=1.
- cmd=RIGHT, line held 000 during TURN → fault=1, direction=0 at TIMEOUT_CYCLES. A later cmd_valid is not accepted.
- FOLLOW then line 000 after a 001 correction → direction holds 2. Return to 010 before timeout → direction=1, no fault.
- cmd=HALT, 111 reached → direction=0 with done the next edge. rst_n=0 mid-CROSS → direction=0 on that edge and IDLE after release.

Source files
------------

// File: rtl/sm1118_pkg.sv
// Shared codes for the line-follow sequencer: motor direction codes, node commands, FSM states.
// Latency: n/a (constants and a pure decode function only).
// Backpressure: n/a.
package sm1118_pkg;

    // Motor direction codes, numbered as the motor driver decodes them
    localparam logic [2:0] DIR_STOP        = 3'd0;
    localparam logic [2:0] DIR_FWD         = 3'd1;
    localparam logic [2:0] DIR_RIGHT       = 3'd2;
    localparam logic [2:0] DIR_LEFT        = 3'd3;
    localparam logic [2:0] DIR_REVERSE     = 3'd4;
    localparam logic [2:0] DIR_PIVOT_RIGHT = 3'd5;
    localparam logic [2:0] DIR_PIVOT_LEFT  = 3'd6;

    // Node commands from the path planner
    localparam logic [1:0] CMD_STRAIGHT = 2'd0;
    localparam logic [1:0] CMD_LEFT     = 2'd1;
    localparam logic [1:0] CMD_RIGHT    = 2'd2;
    localparam logic [1:0] CMD_HALT     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOLLOW = 3'd1,
        ST_CROSS  = 3'd2,
        ST_TURN   = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // Steering for an on-line pattern {L,C,R}; 000 and 111 are handled by the FSM itself
    function automatic logic [2:0] follow_dir(input logic [2:0] pat);
        logic [2:0] d;
        d = DIR_FWD;
        case (pat)
            3'b110, 3'b100: d = DIR_LEFT;
            3'b011, 3'b001: d = DIR_RIGHT;
            default:        d = DIR_FWD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/line_debounce.sv
// Accepts a new value only after DEBOUNCE_CYCLES identical consecutive input samples.
// Latency: stable updates on the edge that sees the DEBOUNCE_CYCLES-th equal sample; changed pulses with it.
// Backpressure: none, free-running every cycle.
module line_debounce #(
    parameter int               WIDTH           = 3,
    parameter int               DEBOUNCE_CYCLES = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             changed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] last;
    logic [CW-1:0]    run;
    logic [CW-1:0]    run_next;

    // Length of the run of identical samples including the current one, saturating
    always_comb begin
        run_next = CW'(1);
        if (raw == last) begin
            run_next = (run == CW'(DEBOUNCE_CYCLES)) ? run : run + CW'(1);
        end
    end

    // Track the run and commit the value once the run is long enough
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last    <= RESET_VALUE;
            run     <= '0;
            stable  <= RESET_VALUE;
            changed <= 1'b0;
        end else begin
            last    <= raw;
            run     <= run_next;
            changed <= 1'b0;
            if (run_next == CW'(DEBOUNCE_CYCLES) && raw != stable) begin
                stable  <= raw;
                changed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_follow_sequencer.sv
// Turns debounced line sensors plus one node command into motor direction codes; reports done/fault.
// Latency: raw line change to direction change is DEBOUNCE_CYCLES+2 edges; done is a one-cycle pulse.
// Backpressure: cmd_ready only in IDLE; cmd_valid elsewhere is dropped, never queued.
module line_follow_sequencer
    import sm1118_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CROSS_CYCLES    = 31250,
    parameter int TURN_MIN_CYCLES = 156250,
    parameter int TIMEOUT_CYCLES  = 3125000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] line,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic [2:0] direction,
    output logic       done,
    output logic       fault
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    logic [2:0]       line_q;
    logic [2:0]       pat;
    logic             unused_pat_changed;  // FSM re-evaluates every cycle, so the change strobe is not needed
    logic [1:0]       cmd_q;
    logic [2:0]       last_corr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Register the raw sensors once before debouncing
    always_ff @(posedge clk) begin
        if (!rst_n) line_q <= 3'b010;
        else        line_q <= line;
    end

    line_debounce #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (3'b010)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (line_q),
        .stable  (pat),
        .changed (unused_pat_changed)
    );

    assign cmd_ready = (state == ST_IDLE);

    // Saturating increment so the shared counter can never wrap
    always_comb begin
        cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    end

    // Sequencer FSM with registered direction/done/fault; counter cleared on every state entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            direction <= DIR_STOP;
            done      <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
            cmd_q     <= CMD_STRAIGHT;
            last_corr <= DIR_FWD;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    direction <= DIR_STOP;
                    cnt       <= '0;
                    if (cmd_valid) begin
                        cmd_q <= cmd;
                        if (cmd == CMD_HALT && pat == 3'b111) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FOLLOW;
                        end
                    end
                end
                ST_FOLLOW: begin
                    if (pat == 3'b111) begin
                        cnt <= '0;
                        if (cmd_q == CMD_HALT) begin
                            state     <= ST_DONE;
                            direction <= DIR_STOP;
                            done      <= 1'b1;
                        end else begin
                            state     <= ST_CROSS;
                            direction <= DIR_FWD;
                        end
                    end else if (pat == 3'b000) begin
                        if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
                            state     <= ST_FAULT;
                            direction <= DIR_STOP;
                            fault     <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            direction <= last_corr;
                            cnt       <= cnt_inc;
                        end
                    end else begin
                        direction <= follow_dir(pat);
                        last_corr <= follow_dir(pat);
                        cnt       <= '0;
                    end
                end
                ST_CROSS: begin
                    if (cnt_inc >= CNT_W'(CROSS_CYCLES)) begin
                        cnt <= '0;
                        case (cmd_q)
                            CMD_LEFT: begin
                                state     <= ST_TURN;
                                direction <= DIR_PIVOT_LEFT;
                            end
                            CMD_RIGHT: begin
                                state     <= ST_TURN;
                                direction <= DIR_PIVOT_RIGHT;
                            end
                            default: begin
                                state     <= ST_DONE;
                                direction <= DIR_STOP;
                                done      <= 1'b1;
                            end
                        endcase
                    end else begin
                        direction <= DIR_FWD;
                        cnt       <= cnt_inc;
                    end
                end
                ST_TURN: begin
                    // Timeout is checked first so it wins over a same-edge line reacquire
                    if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
                        state     <= ST_FAULT;
                        direction <= DIR_STOP;
                        fault     <= 1'b1;
                        cnt       <= '0;
                    end else if (cnt >= CNT_W'(TURN_MIN_CYCLES) && pat[1] && pat != 3'b111) begin
                        state     <= ST_DONE;
                        direction <= DIR_STOP;
                        done      <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    direction <= DIR_STOP;
                    cnt       <= '0;
                end
                ST_FAULT: begin
                    direction <= DIR_STOP;
                    fault     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    direction <= DIR_STOP;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Directed bench for line_follow_sequencer with a per-cycle reference model and literal spot checks.
// Latency: timing constants are shortened so the whole run stays small.
// Backpressure: exercises dropped commands outside IDLE and after a fault.
module tb_line_follow_sequencer;

    localparam int DB = 3;
    localparam int CR = 20;
    localparam int TM = 60;
    localparam int TO = 200;

    localparam int P_IDLE   = 0;
    localparam int P_FOLLOW = 1;
    localparam int P_CROSS  = 2;
    localparam int P_TURN   = 3;
    localparam int P_DONE   = 4;
    localparam int P_FAULT  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] line;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic [2:0] direction;
    logic       done;
    logic       fault;

    always #5 clk = ~clk;

    line_follow_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .CROSS_CYCLES    (CR),
        .TURN_MIN_CYCLES (TM),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line      (line),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .direction (direction),
        .done      (done),
        .fault     (fault)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_valid = 1'b0;
    int         m_phase;
    int         cyc = 0;
    int         start;
    int         lost_run;
    logic [2:0] m_dir;
    bit         m_done;
    bit         m_fault;
    logic [2:0] m_last;
    logic [2:0] m_pat;
    logic [1:0] m_cmd;
    int         hist [3];

    function automatic void enter(input int ph);
        m_phase  = ph;
        start    = cyc;
        lost_run = 0;
        if (ph == P_DONE)  begin m_dir = 3'd0; m_done = 1'b1; end
        if (ph == P_FAULT) begin m_dir = 3'd0; m_fault = 1'b1; end
    endfunction

    always @(posedge clk) begin
        int k;
        logic [2:0] p;
        cyc++;
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_phase  = P_IDLE;
            start    = cyc;
            lost_run = 0;
            m_dir    = 3'd0;
            m_done   = 1'b0;
            m_fault  = 1'b0;
            m_last   = 3'd1;
            m_pat    = 3'b010;
            m_cmd    = 2'd0;
            hist[0]  = 2;
            hist[1]  = -1;
            hist[2]  = -1;
        end else if (m_valid) begin
            k      = cyc - start;
            p      = m_pat;
            m_done = 1'b0;
            case (m_phase)
                P_IDLE: begin
                    m_dir = 3'd0;
                    if (cmd_valid) begin
                        m_cmd = cmd;
                        if (cmd == 2'd3 && p == 3'b111) enter(P_DONE);
                        else                            enter(P_FOLLOW);
                    end
                end
                P_FOLLOW: begin
                    if (p == 3'b111) begin
                        if (m_cmd == 2'd3) enter(P_DONE);
                        else begin enter(P_CROSS); m_dir = 3'd1; end
                    end else if (p == 3'b000) begin
                        lost_run++;
                        if (lost_run == TO) enter(P_FAULT);
                        else                m_dir = m_last;
                    end else begin
                        lost_run = 0;
                        if (p == 3'b010 || p == 3'b101)      m_dir = 3'd1;
                        else if (p == 3'b110 || p == 3'b100) m_dir = 3'd3;
                        else                                 m_dir = 3'd2;
                        m_last = m_dir;
                    end
                end
                P_CROSS: begin
                    if (k == CR) begin
                        if (m_cmd == 2'd1)      begin enter(P_TURN); m_dir = 3'd6; end
                        else if (m_cmd == 2'd2) begin enter(P_TURN); m_dir = 3'd5; end
                        else                    enter(P_DONE);
                    end else begin
                        m_dir = 3'd1;
                    end
                end
                P_TURN: begin
                    if (k >= TO)                               enter(P_FAULT);
                    else if (k > TM && p[1] && p != 3'b111)    enter(P_DONE);
                end
                P_DONE: begin
                    m_dir = 3'd0;
                    enter(P_IDLE);
                end
                default: begin
                    m_dir   = 3'd0;
                    m_fault = 1'b1;
                end
            endcase
            // debounced pattern: last DB registered samples all equal
            if (hist[0] >= 0 && hist[0] == hist[1] && hist[1] == hist[2]) m_pat = 3'(hist[0]);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = int'(line);
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [5:0] exp_v;
        if (m_valid) begin
            exp_v = {(m_phase == P_IDLE), m_done, m_fault, m_dir};
            check("cycle", {26'd0, cmd_ready, done, fault, direction}, {26'd0, exp_v});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int obs;
        rst_n = 1'b0; line = 3'b010; cmd_valid = 1'b0; cmd = 2'd0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_dir", direction, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_fault", fault, 0);

        // STRAIGHT accepted, line centred
        cmd_valid = 1'b1; cmd = 2'd0;
        tick(1);
        cmd_valid = 1'b0;
        check("acc_ready_low", cmd_ready, 0);
        tick(1);
        check("follow_fwd", direction, 1);

        // Left correction appears exactly DB+2 edges after the change
        line = 3'b100;
        tick(DB + 1);
        check("corr_early", direction, 1);
        tick(1);
        check("corr_left", direction, 3);

        // Short glitch rejected
        line = 3'b010; tick(6);
        line = 3'b100; tick(2);
        line = 3'b010; tick(8);
        check("glitch", direction, 1);

        // Line lost after a right correction holds the correction, then recovers
        line = 3'b001; tick(6);
        check("corr_right", direction, 2);
        line = 3'b000; tick(50);
        check("lost_hold", direction, 2);
        check("lost_nofault", fault, 0);
        line = 3'b010; tick(6);
        check("recover", direction, 1);
        check("recover_nofault", fault, 0);

        // Node reached: cross, then complete STRAIGHT
        line = 3'b111;
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(1); n++; end
        check("straight_lat", n, DB + 2 + CR);
        check("straight_done_dir", direction, 0);
        tick(1);
        check("straight_pulse", done, 0);
        check("straight_ready", cmd_ready, 1);

        // LEFT with node already present
        cmd_valid = 1'b1; cmd = 2'd1;
        tick(1);
        cmd_valid = 1'b0;
        tick(1);
        check("cross_start", direction, 1);
        obs = 1;
        n = 0;
        while (n < 100) begin
            tick(1); n++;
            if (direction === 3'd1) obs++;
            else break;
        end
        check("cross_len", obs, CR);
        check("pivot_left", direction, 6);
        obs = 1;
        line = 3'b000; tick(20); obs += 20;
        line = 3'b010; tick(10); obs += 10;
        check("turn_ignore", direction, 6);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick(1); n++;
            if (done !== 1'b1) obs++;
        end
        check("turn_done_seen", done, 1);
        check("turn_len", obs, TM + 1);
        check("turn_done_dir", direction, 0);
        tick(1);
        check("turn_pulse", done, 0);
        check("turn_ready", cmd_ready, 1);

        // RIGHT with the line never found: turn timeout
        line = 3'b111; tick(6);
        cmd_valid = 1'b1; cmd = 2'd2;
        tick(1);
        cmd_valid = 1'b0;
        line = 3'b000;
        n = 0;
        while (direction !== 3'd5 && n < 100) begin tick(1); n++; end
        check("pivot_right", direction, 5);
        obs = 1;
        n = 0;
        while (fault !== 1'b1 && n < 2 * TO) begin
            tick(1); n++;
            if (fault !== 1'b1) obs++;
        end
        check("timeout_len", obs, TO);
        check("fault_set", fault, 1);
        check("fault_dir", direction, 0);
        check("fault_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd = 2'd0;
        tick(5);
        cmd_valid = 1'b0;
        check("fault_sticky", fault, 1);
        check("fault_no_accept", cmd_ready, 0);
        check("fault_dir_hold", direction, 0);

        // Reset clears the fault; HALT at a node
        rst_n = 1'b0; tick(2);
        rst_n = 1'b1; line = 3'b010; tick(6);
        check("clr_fault", fault, 0);
        check("clr_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd = 2'd3;
        tick(1);
        cmd_valid = 1'b0;
        tick(3);
        check("halt_follow", direction, 1);
        line = 3'b111;
        n = 0;
        while (done !== 1'b1 && n < 50) begin tick(1); n++; end
        check("halt_lat", n, DB + 2);
        check("halt_dir", direction, 0);
        tick(1);
        check("halt_ready", cmd_ready, 1);

        // HALT accepted while already on a node completes at once
        cmd_valid = 1'b1; cmd = 2'd3;
        tick(1);
        cmd_valid = 1'b0;
        check("halt_now_done", done, 1);
        tick(1);

        // Reset in the middle of a crossing
        cmd_valid = 1'b1; cmd = 2'd0;
        tick(1);
        cmd_valid = 1'b0;
        tick(6);
        check("midcross_fwd", direction, 1);
        rst_n = 1'b0;
        tick(1);
        check("midcross_rst_dir", direction, 0);
        rst_n = 1'b1;
        tick(1);
        check("after_rst_ready", cmd_ready, 1);
        check("after_rst_dir", direction, 0);
        check("after_rst_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
